pipeline_ctrl: RTL and testbench



---
 rtl/pipeline_ctrl_if.sv | 35 +++
 rtl/pipeline_ctrl.sv | 132 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/pipeline_ctrl_if.sv
// Hazard/event inputs and pipeline-register controls exchanged between
// the datapath (master) and the stall/flush sequencer (slave).
interface pipeline_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             load_use;
   logic             br_dep;
   logic             br_taken;
   logic             jump_id;
   logic             halt_id;
   logic             md_req;
   logic             md_done;
   logic             pc_write;
   logic             if_id_write;
   logic             if_id_flush;
   logic             id_ex_write;
   logic             id_ex_bubble;
   logic             ex_mem_bubble;
   logic             md_start;
   logic             halted;
   logic [1:0]       state;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output load_use, br_dep, br_taken, jump_id, halt_id, md_req, md_done,
      input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
             ex_mem_bubble, md_start, halted, state, stall_cycles
   );

   modport slave (
      input  load_use, br_dep, br_taken, jump_id, halt_id, md_req, md_done,
      output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble,
             ex_mem_bubble, md_start, halted, state, stall_cycles
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: fixed-priority hazard
// arbitration, mult/div wait, halt drain and a saturating stall counter.
//
// state   | meaning
// RUN     | normal issue; hazards arbitrated per cycle
// MD_WAIT | front end frozen until the mult/div unit reports done
// DRAIN   | halt in flight; fetch squashed while older work retires
// HALTED  | pipeline stopped until reset
module pipeline_ctrl #(
   parameter int DRAIN_CYCLES = 3,
   parameter int CNT_W        = 16
) (
   input logic           clk,
   input logic           rst,
   pipeline_ctrl_if.slave pipe
);
   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MD_WAIT = 2'd1,
      DRAIN   = 2'd2,
      HALTED  = 2'd3
   } ctrl_state_t;

   ctrl_state_t      ctrlState;
   ctrl_state_t      nextState;
   logic [DW-1:0]    drainCnt;
   logic [DW-1:0]    drainNext;
   logic [CNT_W-1:0] stallCnt;

   logic pcWrite;
   logic ifIdWrite;
   logic ifIdFlush;
   logic idExWrite;
   logic idExBubble;
   logic exMemBubble;
   logic mdStart;
   logic haltedFlag;
   logic stallEvent;

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrlState <= RUN;
         drainCnt  <= '0;
         stallCnt  <= '0;
      end else begin
         ctrlState <= nextState;
         drainCnt  <= drainNext;
         if (stallEvent && (stallCnt != '1))
            stallCnt <= stallCnt + CNT_W'(1);
      end
   end

   always_comb begin
      pcWrite     = 1'b1;
      ifIdWrite   = 1'b1;
      ifIdFlush   = 1'b0;
      idExWrite   = 1'b1;
      idExBubble  = 1'b0;
      exMemBubble = 1'b0;
      mdStart     = 1'b0;
      haltedFlag  = 1'b0;
      nextState   = ctrlState;
      drainNext   = drainCnt;

      // Reset holds the default enables so nothing is started mid-abort.
      if (!rst) begin
         case (ctrlState)
            RUN: begin
               if (pipe.md_req) begin
                  // ID/EX frozen, so a concurrent load-use needs no bubble.
                  mdStart     = 1'b1;
                  pcWrite     = 1'b0;
                  ifIdWrite   = 1'b0;
                  idExWrite   = 1'b0;
                  exMemBubble = 1'b1;
                  nextState   = MD_WAIT;
               end else if (pipe.load_use || pipe.br_dep) begin
                  pcWrite    = 1'b0;
                  ifIdWrite  = 1'b0;
                  idExBubble = 1'b1;
               end else if (pipe.halt_id) begin
                  pcWrite   = 1'b0;
                  drainNext = DW'(DRAIN_CYCLES - 1);
                  nextState = DRAIN;
               end else if (pipe.br_taken || pipe.jump_id) begin
                  ifIdFlush = 1'b1;
               end
            end
            MD_WAIT: begin
               if (pipe.md_done) begin
                  nextState = RUN;
               end else begin
                  pcWrite     = 1'b0;
                  ifIdWrite   = 1'b0;
                  idExWrite   = 1'b0;
                  exMemBubble = 1'b1;
               end
            end
            DRAIN: begin
               pcWrite   = 1'b0;
               ifIdFlush = 1'b1;
               if (drainCnt == '0)
                  nextState = HALTED;
               else
                  drainNext = drainCnt - DW'(1);
            end
            HALTED: begin
               pcWrite    = 1'b0;
               ifIdWrite  = 1'b0;
               idExBubble = 1'b1;
               haltedFlag = 1'b1;
            end
            default: nextState = RUN;
         endcase
      end
   end

   assign stallEvent = !pcWrite && ((ctrlState == RUN) || (ctrlState == MD_WAIT));

   assign pipe.pc_write      = pcWrite;
   assign pipe.if_id_write   = ifIdWrite;
   assign pipe.if_id_flush   = ifIdFlush;
   assign pipe.id_ex_write   = idExWrite;
   assign pipe.id_ex_bubble  = idExBubble;
   assign pipe.ex_mem_bubble = exMemBubble;
   assign pipe.md_start      = mdStart;
   assign pipe.halted        = haltedFlag;
   assign pipe.state         = ctrlState;
   assign pipe.stall_cycles  = stallCnt;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl: stimulus queues expected
// output vectors, a negedge monitor pops and compares them.
module tb_pipeline_ctrl;
   localparam int CNT_W        = 16;
   localparam int DRAIN_CYCLES = 3;

   // flags: pc_write, if_id_write, if_id_flush, id_ex_write,
   //        id_ex_bubble, ex_mem_bubble, md_start, halted
   localparam logic [7:0] F_DEF  = 8'b1101_0000;
   localparam logic [7:0] F_STL  = 8'b0001_1000;
   localparam logic [7:0] F_MDS  = 8'b0000_0110;
   localparam logic [7:0] F_MDW  = 8'b0000_0100;
   localparam logic [7:0] F_BR   = 8'b1111_0000;
   localparam logic [7:0] F_HACC = 8'b0101_0000;
   localparam logic [7:0] F_DRN  = 8'b0111_0000;
   localparam logic [7:0] F_HLT  = 8'b0001_1001;

   // inputs: load_use, br_dep, br_taken, jump_id, halt_id, md_req, md_done
   localparam logic [6:0] I_NONE = 7'b000_0000;
   localparam logic [6:0] I_LU   = 7'b100_0000;
   localparam logic [6:0] I_BD   = 7'b010_0000;
   localparam logic [6:0] I_BT   = 7'b001_0000;
   localparam logic [6:0] I_JP   = 7'b000_1000;
   localparam logic [6:0] I_HT   = 7'b000_0100;
   localparam logic [6:0] I_MR   = 7'b000_0010;
   localparam logic [6:0] I_MD   = 7'b000_0001;

   logic clk = 1'b0;
   logic rst = 1'b1;

   pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipeline_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
      .clk  (clk),
      .rst  (rst),
      .pipe (bus)
   );

   always #5 clk = ~clk;

   logic [25:0] expQ[$];
   string       nameQ[$];
   int          checks = 0;
   int          errors = 0;

   logic [25:0] monExp;
   logic [25:0] monAct;
   string       monName;

   function automatic logic [25:0] mk(input logic [7:0] flags, input logic [1:0] st, input int stall);
      logic [31:0] s;
      s = stall;
      return {flags, st, s[15:0]};
   endfunction

   task automatic step(input logic r, input logic [6:0] in, input logic doChk,
                       input logic [25:0] ex, input string nm);
      @(posedge clk);
      #1;
      rst = r;
      {bus.load_use, bus.br_dep, bus.br_taken, bus.jump_id,
       bus.halt_id, bus.md_req, bus.md_done} = in;
      if (doChk) begin
         expQ.push_back(ex);
         nameQ.push_back(nm);
      end
   endtask

   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         monExp  = expQ.pop_front();
         monName = nameQ.pop_front();
         monAct  = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_ex_write,
                    bus.id_ex_bubble, bus.ex_mem_bubble, bus.md_start, bus.halted,
                    bus.state, bus.stall_cycles};
         checks++;
         if (monAct !== monExp) begin
            errors++;
            $display("FAIL %s: got flags=%b state=%0d stall=%h, expected flags=%b state=%0d stall=%h",
                     monName, monAct[25:18], monAct[17:16], monAct[15:0],
                     monExp[25:18], monExp[17:16], monExp[15:0]);
         end
      end
   end

   initial begin
      int waitBudget;
      {bus.load_use, bus.br_dep, bus.br_taken, bus.jump_id,
       bus.halt_id, bus.md_req, bus.md_done} = I_NONE;

      step(1, I_MR, 1, mk(F_DEF, 0, 0), "rst_forces_default");
      step(0, I_NONE, 1, mk(F_DEF, 0, 0), "idle_after_rst");
      step(0, I_LU, 1, mk(F_STL, 0, 0), "load_use_stall");
      step(0, I_NONE, 1, mk(F_DEF, 0, 1), "after_load_use");

      step(0, I_MR, 1, mk(F_MDS, 0, 1), "md_start");
      for (int i = 0; i < 4; i++)
         step(0, I_MR, 1, mk(F_MDW, 1, 2 + i), "md_wait");
      step(0, I_MR | I_MD, 1, mk(F_DEF, 1, 6), "md_done");
      step(0, I_NONE, 1, mk(F_DEF, 0, 6), "md_back_to_run");

      step(0, I_MR | I_LU, 1, mk(F_MDS, 0, 6), "md_beats_load_use");
      step(0, I_MD, 1, mk(F_DEF, 1, 7), "md_min_wait");
      step(0, I_NONE, 1, mk(F_DEF, 0, 7), "run_after_min_wait");

      step(0, I_BT, 1, mk(F_BR, 0, 7), "br_taken_flush");
      step(0, I_JP, 1, mk(F_BR, 0, 7), "jump_flush");
      step(0, I_BT | I_BD, 1, mk(F_STL, 0, 7), "br_dep_beats_branch");
      step(0, I_BT | I_LU, 1, mk(F_STL, 0, 8), "load_use_beats_branch");
      step(0, I_NONE, 1, mk(F_DEF, 0, 9), "after_branch_stalls");

      step(0, I_HT, 1, mk(F_HACC, 0, 9), "halt_accept");
      step(0, I_MR, 1, mk(F_DRN, 2, 10), "drain_1");
      step(0, I_BT | I_LU, 1, mk(F_DRN, 2, 10), "drain_2");
      step(0, I_HT, 1, mk(F_DRN, 2, 10), "drain_3");
      step(0, I_MR, 1, mk(F_HLT, 3, 10), "halted_ignores_md");
      step(0, I_BT, 1, mk(F_HLT, 3, 10), "halted_ignores_br");
      step(0, I_NONE, 1, mk(F_HLT, 3, 10), "halted_hold");

      step(1, I_NONE, 1, mk(F_DEF, 3, 10), "rst_in_halted");
      step(0, I_NONE, 1, mk(F_DEF, 0, 0), "after_halted_rst");
      step(0, I_HT, 1, mk(F_HACC, 0, 0), "halt_again");
      step(0, I_NONE, 1, mk(F_DRN, 2, 1), "drain_again");
      step(1, I_NONE, 0, '0, "");
      step(0, I_NONE, 1, mk(F_DEF, 0, 0), "rst_aborts_drain");
      step(0, I_NONE, 1, mk(F_DEF, 0, 0), "no_halt_after_abort");

      step(0, I_MR, 1, mk(F_MDS, 0, 0), "md_start_2");
      step(0, I_MR, 1, mk(F_MDW, 1, 1), "md_wait_2");
      step(1, I_MR, 1, mk(F_DEF, 1, 2), "rst_in_md_wait");
      step(0, I_NONE, 1, mk(F_DEF, 0, 0), "after_md_rst");

      for (int i = 0; i < 70000; i++)
         step(0, I_LU, (i == 65534) || (i == 65535) || (i == 69999),
              mk(F_STL, 0, (i < 65535) ? i : 65535), "stall_saturation");
      step(0, I_NONE, 1, mk(F_DEF, 0, 65535), "saturated_hold");

      waitBudget = 0;
      while (expQ.size() > 0 && waitBudget < 5) begin
         @(posedge clk);
         waitBudget++;
      end
      if (expQ.size() > 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
